// File: rtl/msx_slot_router.sv
// Primary/secondary slot router: secondary-slot registers at 0xFFFF, slot layout
// index decode, and a request/acknowledge memory cycle with CPU wait and timeout.
module msx_slot_router #(
    parameter int         NUM_SLOTS = 4,
    parameter logic [3:0] EXP_MASK  = 4'b1000,
    parameter int         TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        cpu_mreq,
    input  logic [1:0]  active_slot,
    output logic [5:0]  layout_id,
    output logic        subslot_cs,
    output logic        mem_req,
    output logic        mem_rnw,
    input  logic        mem_ack,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  data,
    output logic        cpu_wait,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [2:0] NUM_SLOTS_L = 3'(NUM_SLOTS);
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  ssr_q [4];
    logic [7:0]  ssr_d [4];
    logic [7:0]  data_q, data_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_rnw_q, mem_rnw_d;
    logic        timeout_err_q, timeout_err_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        cyc_term_q;

    logic        slot_valid_s;
    logic        subslot_cs_s;
    logic        cyc_term_s;
    logic        cyc_start_s;
    logic        wait_s;
    logic [7:0]  cur_ssr_s;
    logic [1:0]  subslot_s;

    assign slot_valid_s = ({1'b0, active_slot} < NUM_SLOTS_L);
    assign subslot_cs_s = cpu_mreq & (cpu_addr == 16'hFFFF) & EXP_MASK[active_slot] & slot_valid_s;
    assign cyc_term_s   = cpu_mreq & (cpu_rd | cpu_wr);
    assign cyc_start_s  = cyc_term_s & ~cyc_term_q;
    assign cur_ssr_s    = ssr_q[active_slot];
    assign subslot_s    = cur_ssr_s[{cpu_addr[15:14], 1'b0} +: 2];

    assign layout_id   = {active_slot, subslot_s, cpu_addr[15:14]};
    assign subslot_cs  = subslot_cs_s;
    assign mem_req     = mem_req_q;
    assign mem_rnw     = mem_rnw_q;
    assign data        = data_q;
    assign timeout_err = timeout_err_q;
    // Wait must rise on the start edge itself, and stay low while reset is held.
    assign cpu_wait    = reset & wait_s;

    // Next-state, register-file and output decode for the cycle FSM.
    always_comb begin
        state_d       = state_q;
        ssr_d         = ssr_q;
        data_d        = data_q;
        mem_req_d     = 1'b0;
        mem_rnw_d     = mem_rnw_q;
        timeout_err_d = timeout_err_q;
        tmo_cnt_d     = tmo_cnt_q;
        wait_s        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cyc_start_s) begin
                    if (subslot_cs_s) begin
                        // A combined rd+wr strobe is a write.
                        if (cpu_wr) begin
                            ssr_d[active_slot] = cpu_data;
                        end else begin
                            data_d = ~cur_ssr_s;
                        end
                        state_d = ST_HOLD;
                    end else if (!slot_valid_s) begin
                        data_d  = 8'hFF;
                        state_d = ST_HOLD;
                    end else begin
                        mem_req_d = 1'b1;
                        mem_rnw_d = cpu_rd & ~cpu_wr;
                        wait_s    = 1'b1;
                        state_d   = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                wait_s    = 1'b1;
                tmo_cnt_d = 8'd0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                wait_s = 1'b1;
                if (mem_ack) begin
                    if (mem_rnw_q) begin
                        data_d = mem_dout;
                    end else begin
                        data_d = data_q;
                    end
                    state_d = ST_HOLD;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    data_d        = 8'hFF;
                    timeout_err_d = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (!cpu_mreq) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Slots that are not expanded or not decoded have no register.
        for (int n = 0; n < 4; n++) begin
            if (!(EXP_MASK[n] && (n < NUM_SLOTS))) begin
                ssr_d[n] = 8'h00;
            end else begin
                ssr_d[n] = ssr_d[n];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            for (int n = 0; n < 4; n++) begin
                ssr_q[n] <= 8'h00;
            end
            data_q        <= 8'hFF;
            mem_req_q     <= 1'b0;
            mem_rnw_q     <= 1'b1;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= 8'd0;
            cyc_term_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ssr_q         <= ssr_d;
            data_q        <= data_d;
            mem_req_q     <= mem_req_d;
            mem_rnw_q     <= mem_rnw_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cyc_term_q    <= cyc_term_s;
        end
    end

endmodule

// File: doc/msx_slot_router.md
# msx_slot_router

Parametrised primary/secondary slot router that replaces the fixed single-expander slot front end. It holds one secondary-slot register per expandable primary slot and resolves every CPU memory cycle into a 6-bit slot layout index. It runs each non-register cycle as a request/acknowledge transaction toward the memory back end, with CPU wait insertion and a timeout. It sits between the CPU bus and the slot layout / mapper logic.

## Interface
Parameters:
- NUM_SLOTS, 4, number of primary slots decoded (1..4); `active_slot` values >= NUM_SLOTS read as 0xFF with no request.
- EXP_MASK, 4'b1000, bit n set = primary slot n is expanded (has a register at 0xFFFF).
- TIMEOUT, 15, cycles after `mem_req` before an unacknowledged cycle is aborted (1..255).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_data  in  8  CPU write data.
- cpu_wr  in  1  CPU write strobe.
- cpu_rd  in  1  CPU read strobe.
- cpu_mreq  in  1  CPU memory request.
- active_slot  in  2  primary slot currently selected for cpu_addr[15:14].
- layout_id  out  6  {active_slot, subslot, cpu_addr[15:14]}, combinational from current registers.
- subslot_cs  out  1  current cycle targets a secondary-slot register.
- mem_req  out  1  single-cycle request pulse to the memory back end.
- mem_rnw  out  1  1 = read, 0 = write; valid with mem_req.
- mem_ack  in  1  back end completion; sampled only in state WAIT.
- mem_dout  in  8  read data, valid with mem_ack.
- data  out  8  registered read data to the CPU.
- cpu_wait  out  1  CPU wait request.
- timeout_err  out  1  sticky; set on any aborted cycle, cleared only by reset.

## Operation
- Registers: `ssr[n]` (8 bits) for each n with EXP_MASK[n]=1 and n<NUM_SLOTS; all others are constant 0.
- subslot for block b = ssr[active_slot][2b+1:2b].
- Register hit: subslot_cs = cpu_mreq & cpu_addr==16'hFFFF & EXP_MASK[active_slot] & active_slot<NUM_SLOTS.
- Cycle start: rising edge of (cpu_mreq & (cpu_rd | cpu_wr)), from a one-cycle-delayed copy of the same term.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE, on cycle start with subslot_cs:
  - write: ssr[active_slot] <= cpu_data.
  - read: data <= ~ssr[active_slot].
  - Next state HOLD; no mem_req.
- IDLE, on cycle start with active_slot >= NUM_SLOTS: data <= 8'hFF; next state HOLD.
- IDLE, on any other cycle start: next state REQ; cpu_wait rises in the same cycle (combinational on the start edge).
- REQ: mem_req=1 for exactly one cycle; mem_rnw = cpu_rd; timeout counter cleared. Next state WAIT.
- WAIT:
  - mem_ack=1: data <= mem_dout if read; next state HOLD.
  - Counter reaches TIMEOUT without ack: data <= 8'hFF; timeout_err <= 1; next state HOLD.
- HOLD: cpu_wait=0. Return to IDLE when cpu_mreq=0. A late mem_ack in HOLD or IDLE is ignored.
- cpu_wait = 1 in REQ and WAIT, and on the start cycle of a request in IDLE.
- Simultaneous cpu_rd and cpu_wr: treated as a write (mem_rnw=0); registers are written, not read.
- Asserting reset mid-cycle returns to IDLE immediately, with all outputs at reset values; the back end sees mem_req drop.

## Timing
- Reset values: ssr=0, data=8'hFF, mem_req=0, mem_rnw=1, cpu_wait=0, timeout_err=0, state IDLE.
- Register write is visible on layout_id the cycle after the start edge (1-cycle latency).
- Register read: data is valid 1 cycle after the start edge.
- Memory cycle: mem_req asserts 1 cycle after the start edge. The earliest ack is the cycle after mem_req. data is valid and cpu_wait falls 1 cycle after the ack.
- Timeout: cpu_wait falls TIMEOUT+1 cycles after mem_req.
- layout_id has zero latency from cpu_addr and active_slot.

## Test plan
- Reset, then write 8'hE4 to 0xFFFF with active_slot=3 -> no mem_req; ssr[3]=E4; addr 4000h gives layout_id={3,1,1}=6'h35; a read of 0xFFFF returns 8'h1B.
- active_slot=0 (not expanded), write 0xFFFF -> mem_req with mem_rnw=0; layout_id subslot field stays 0.
- Read at 8000h, ack 3 cycles after mem_req with mem_dout=5A -> cpu_wait high for 5 cycles; data=5A; single mem_req pulse.
- No ack, TIMEOUT=15 -> cpu_wait falls 16 cycles after mem_req; data=FF; timeout_err=1; a late ack is ignored and the next cycle is normal.
- NUM_SLOTS=2, active_slot=3 read -> data=FF; no mem_req; no wait.
- Assert reset during WAIT -> mem_req=0, cpu_wait=0, ssr cleared; after release, a new cycle completes normally.
